ins_cache_dm_r32i: RTL and testbench

Parametrised direct-mapped instruction cache for the R32I core, sitting between the PC/fetch stage and instruction RAM. It holds `NumLines` lines of `LineWords` 32-bit instructions with per-line tag and valid state. On a miss it stalls the PC and refills the whole line over a req/ack memory handshake. It adds a flush input for `fence.i`, misaligned-address detection and a saturating miss counter.

---
 rtl/ins_cache_dm_r32i.sv | 180 ++++++++++++++++++
 tb/tb_ins_cache_dm_r32i.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache_dm_r32i.sv
// ins_cache_dm_r32i
// Direct-mapped instruction cache for the R32I core. It sits between the
// PC/fetch stage and instruction RAM. On a miss it stalls the PC and refills
// the whole line from RAM, one word per acknowledged request beat.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-low reset
//   ProgAddr      byte address from the PC
//   Flush         one-cycle pulse that invalidates every line (fence.i)
//   MemAck        RAM accepted MemAddr; MemData is valid in the same cycle
//   MemData       instruction word returned by RAM
//   OutputIns     instruction to the decoder (NOP unless hit)
//   InsCacheStall PC must hold
//   Misaligned    ProgAddr is not word aligned
//   MemReq        read request to RAM, high for the whole burst
//   MemAddr       byte address of the word currently requested
//   MissCount     saturating count of misses

module ins_cache_dm_r32i #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16,
    parameter int NumLines    = 16,
    parameter int LineWords   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [dataW-1:0]       ProgAddr,
    input  logic                   Flush,
    input  logic                   MemAck,
    input  logic [dataW-1:0]       MemData,
    output logic [dataW-1:0]       OutputIns,
    output logic                   InsCacheStall,
    output logic                   Misaligned,
    output logic                   MemReq,
    output logic [RAMAddrSize-1:0] MemAddr,
    output logic [31:0]            MissCount
);

    localparam int BeatW = $clog2(LineWords);
    localparam int OffW  = BeatW + 2;
    localparam int IdxW  = $clog2(NumLines);
    localparam int TagW  = dataW - OffW - IdxW;

    localparam logic [dataW-1:0]       Nop        = dataW'(32'h0000_0013);
    localparam logic [BeatW-1:0]       LastBeat   = BeatW'(LineWords - 1);
    localparam logic [RAMAddrSize-1:0] OffsetMask = RAMAddrSize'((1 << OffW) - 1);

    typedef enum logic {
        Idle,
        Fill
    } state_t;

    state_t state;
    state_t nextState;

    // Storage: only the valid bits carry reset state.
    logic [dataW-1:0] dataMem [NumLines*LineWords];
    logic [TagW-1:0]  tagMem  [NumLines];
    logic [NumLines-1:0] valid;

    // Fields of the current fetch address.
    logic [IdxW-1:0]  index;
    logic [BeatW-1:0] word;
    logic [TagW-1:0]  tag;

    // Line being refilled, captured when the miss is accepted.
    logic [RAMAddrSize-1:0] fillBase;
    logic [IdxW-1:0]        fillIndex;
    logic [TagW-1:0]        fillTag;
    logic [BeatW-1:0]       beat;
    logic                   flushPending;
    logic [31:0]            missCount;

    logic hit;
    logic startFill;
    logic beatAck;
    logic lastAck;

    assign index = ProgAddr[OffW+IdxW-1:OffW];
    assign word  = ProgAddr[OffW-1:2];
    assign tag   = ProgAddr[dataW-1:OffW+IdxW];

    assign Misaligned = |ProgAddr[1:0];

    // Flush forces a miss in its own cycle, and a misaligned fetch never
    // starts a refill: the trap is raised upstream instead.
    assign hit       = (state == Idle) && valid[index] && (tagMem[index] == tag)
                       && !Misaligned && !Flush;
    assign startFill = (state == Idle) && !hit && !Misaligned && !Flush;

    // An ack only counts while a request is outstanding.
    assign beatAck = (state == Fill) && MemAck;
    assign lastAck = beatAck && (beat == LastBeat);

    assign OutputIns     = hit ? dataMem[{index, word}] : Nop;
    assign InsCacheStall = !hit && !Misaligned;
    assign MemReq        = (state == Fill);
    assign MemAddr       = fillBase + RAMAddrSize'({beat, 2'b00});
    assign MissCount     = missCount;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= Idle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a miss opens a burst, the last acked beat closes it.
    always_comb begin
        nextState = state;
        case (state)
            Idle: if (startFill) nextState = Fill;
            Fill: if (lastAck)   nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    // Beat counter, pending-flush flag and saturating miss counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            beat         <= '0;
            flushPending <= 1'b0;
            missCount    <= '0;
        end else begin
            if (startFill) begin
                beat <= '0;
                if (missCount != 32'hFFFF_FFFF) begin
                    missCount <= missCount + 32'd1;
                end
            end else if (beatAck) begin
                beat <= beat + 1'b1;
            end

            if (lastAck) begin
                flushPending <= 1'b0;
            end else if ((state == Fill) && Flush) begin
                flushPending <= 1'b1;
            end
        end
    end

    // Latch the line being refilled so later PC changes cannot disturb it.
    always_ff @(posedge clock) begin
        if (reset && startFill) begin
            fillBase  <= ProgAddr[RAMAddrSize-1:0] & ~OffsetMask;
            fillIndex <= index;
            fillTag   <= tag;
        end
    end

    // Valid bits: a flush always wins; a line flushed during its own refill
    // is left invalid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= '0;
        end else if (Flush) begin
            valid <= '0;
        end else if (lastAck && !flushPending) begin
            valid[fillIndex] <= 1'b1;
        end
    end

    // Tag is written on the closing beat of the burst.
    always_ff @(posedge clock) begin
        if (reset && lastAck) begin
            tagMem[fillIndex] <= fillTag;
        end
    end

    // Each acknowledged beat lands in its slot of the latched line.
    always_ff @(posedge clock) begin
        if (reset && beatAck) begin
            dataMem[{fillIndex, beat}] <= MemData;
        end
    end

endmodule

// File: tb/tb_ins_cache_dm_r32i.sv
// tb_ins_cache_dm_r32i
// Directed bench for ins_cache_dm_r32i with default parameters
// (16 lines of 4 words). The RAM model returns the word address itself
// as data. Expectations are queued per cycle and drained after the
// outputs have settled.

module tb_ins_cache_dm_r32i;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] progAddr = 32'h0;
    logic        flush = 1'b0;
    logic        memAck = 1'b0;
    logic [31:0] memData;
    logic [31:0] outputIns;
    logic        insCacheStall;
    logic        misaligned;
    logic        memReq;
    logic [15:0] memAddr;
    logic [31:0] missCount;

    int total = 0;
    int bad   = 0;

    typedef enum logic [2:0] {
        SigIns,
        SigStall,
        SigMis,
        SigReq,
        SigAddr,
        SigCnt
    } sigSel_t;

    typedef struct packed {
        sigSel_t     sel;
        logic [31:0] val;
    } expItem_t;

    expItem_t expQ[$];

    ins_cache_dm_r32i dut (
        .clock         (clock),
        .reset         (reset),
        .ProgAddr      (progAddr),
        .Flush         (flush),
        .MemAck        (memAck),
        .MemData       (memData),
        .OutputIns     (outputIns),
        .InsCacheStall (insCacheStall),
        .Misaligned    (misaligned),
        .MemReq        (memReq),
        .MemAddr       (memAddr),
        .MissCount     (missCount)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // RAM model: the word at byte address a holds a.
    assign memData = {16'h0000, memAddr};

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic string sigName(input sigSel_t s);
        case (s)
            SigIns:   return "OutputIns";
            SigStall: return "InsCacheStall";
            SigMis:   return "Misaligned";
            SigReq:   return "MemReq";
            SigAddr:  return "MemAddr";
            default:  return "MissCount";
        endcase
    endfunction

    function automatic logic [31:0] observe(input sigSel_t s);
        case (s)
            SigIns:   return outputIns;
            SigStall: return {31'h0, insCacheStall};
            SigMis:   return {31'h0, misaligned};
            SigReq:   return {31'h0, memReq};
            SigAddr:  return {16'h0, memAddr};
            default:  return missCount;
        endcase
    endfunction

    task automatic expectOut(input sigSel_t s, input logic [31:0] v);
        expItem_t it;
        it.sel = s;
        it.val = v;
        expQ.push_back(it);
    endtask

    task automatic checkOutput();
        expItem_t    it;
        logic [31:0] obs;
        while (expQ.size() > 0) begin
            it  = expQ.pop_front();
            obs = observe(it.sel);
            total++;
            assert (obs === it.val) else begin
                bad++;
                $error("[TB] FAIL %s: observed=%h expected=%h at t=%0t",
                       sigName(it.sel), obs, it.val, $time);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] addr,
                                 input logic fl, input logic ack);
        reset    = rst;
        progAddr = addr;
        flush    = fl;
        memAck   = ack;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        #3;
        checkOutput();
    endtask

    task automatic sampleNow();
        #1;
        checkOutput();
    endtask

    // Four back-to-back acked beats of a burst for the line at base.
    // Leaves the bench one cycle after the closing beat.
    task automatic runFill(input logic [31:0] base, input logic [31:0] cnt);
        for (int b = 0; b < 4; b++) begin
            tick();
            applyStimulus(1'b1, base, 1'b0, 1'b1);
            expectOut(SigReq, 32'd1);
            expectOut(SigAddr, (base + 32'(4 * b)) & 32'h0000_FFFF);
            expectOut(SigStall, 32'd1);
            expectOut(SigCnt, cnt);
            sample();
        end
        tick();
    endtask

    initial begin
        // Reset held for two edges.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            expectOut(SigReq, 32'd0);
            expectOut(SigCnt, 32'd0);
            expectOut(SigStall, 32'd1);
            expectOut(SigIns, Nop);
            sample();
        end

        // Cold start: miss on 0x0, refill, then hit.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd0);
        expectOut(SigIns, Nop);
        sample();
        runFill(32'h0, 32'd1);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h0);
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd1);
        sample();
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h8);
        sampleNow();
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
        expectOut(SigIns, 32'hC);
        sampleNow();

        // Conflict: 0x100 shares index 0 with 0x0.
        tick();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        expectOut(SigIns, Nop);
        expectOut(SigReq, 32'd0);
        sample();
        runFill(32'h100, 32'd2);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h100);
        sample();
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1);
        expectOut(SigIns, 32'h104);
        sampleNow();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        expectOut(SigStall, 32'd1);
        expectOut(SigIns, Nop);
        sampleNow();

        // Refill 0x0 with an ack every third cycle.
        for (int c = 1; c <= 12; c++) begin
            tick();
            applyStimulus(1'b1, 32'h0, 1'b0, (c % 3) == 0);
            expectOut(SigReq, 32'd1);
            expectOut(SigAddr, 32'(4 * ((c - 1) / 3)));
            expectOut(SigStall, 32'd1);
            expectOut(SigCnt, 32'd3);
            sample();
        end
        tick();
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'hC);
        expectOut(SigReq, 32'd0);
        sample();

        // Second valid line at index 1.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        runFill(32'h10, 32'd4);
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h14);
        sample();

        // Flush pulse during beat 2 of the 0x20 refill.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        for (int b = 0; b < 4; b++) begin
            tick();
            applyStimulus(1'b1, 32'h20, b == 2, 1'b1);
            expectOut(SigReq, 32'd1);
            expectOut(SigAddr, 32'h20 + 32'(4 * b));
            expectOut(SigStall, 32'd1);
            expectOut(SigCnt, 32'd5);
            sample();
        end
        tick();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        expectOut(SigIns, Nop);
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd5);
        sample();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        runFill(32'h20, 32'd6);
        applyStimulus(1'b1, 32'h24, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h24);
        sample();

        // Flush while idle on a valid line.
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b1);
        expectOut(SigStall, 32'd1);
        expectOut(SigIns, Nop);
        expectOut(SigReq, 32'd0);
        sampleNow();
        tick();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd6);
        sample();

        // Misaligned fetch: NOP, no stall, no refill.
        applyStimulus(1'b1, 32'h6, 1'b0, 1'b1);
        expectOut(SigMis, 32'd1);
        expectOut(SigIns, Nop);
        expectOut(SigStall, 32'd0);
        expectOut(SigReq, 32'd0);
        sampleNow();
        tick();
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd6);
        expectOut(SigMis, 32'd1);
        expectOut(SigStall, 32'd0);
        sample();

        // Make 0x20 valid again before the reset test.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        expectOut(SigMis, 32'd0);
        expectOut(SigStall, 32'd1);
        sampleNow();
        runFill(32'h20, 32'd7);
        applyStimulus(1'b1, 32'h28, 1'b0, 1'b1);
        expectOut(SigStall, 32'd0);
        expectOut(SigIns, 32'h28);
        sample();

        // Reset asserted during beat 1 of the 0x30 refill.
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        tick();
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b1);
        expectOut(SigReq, 32'd1);
        expectOut(SigAddr, 32'h30);
        expectOut(SigCnt, 32'd8);
        sample();
        tick();
        applyStimulus(1'b0, 32'h30, 1'b0, 1'b1);
        expectOut(SigReq, 32'd1);
        expectOut(SigAddr, 32'h34);
        sample();
        tick();
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1);
        expectOut(SigReq, 32'd0);
        expectOut(SigCnt, 32'd0);
        expectOut(SigStall, 32'd1);
        expectOut(SigIns, Nop);
        sample();
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b1);
        expectOut(SigStall, 32'd1);
        sampleNow();
        tick();
        expectOut(SigReq, 32'd1);
        expectOut(SigAddr, 32'h30);
        expectOut(SigCnt, 32'd1);
        sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
